decoder_scan_n: RTL

- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable. Successor to the team's combinational 3-to-8 decoders.
- Adds two timed modes:
  - SCAN: walks the one-hot output through all lines, each held for a programmable dwell time.
  - ONESHOT: asserts one selected line for a programmed number of cycles.
- Used for row/column strobing, mux-select sequencing and test-pattern generation.

---
 rtl/decoder_scan_n_if.sv | 28 ++
 rtl/decoder_scan_n.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n_if.sv
// Control/status bundle for decoder_scan_n. The master drives the select and timing
// inputs; the slave (the decoder) returns the registered one-hot outputs.
interface decoder_scan_n_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 2 ** SEL_W;

  logic               en;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   i;
  logic               load;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   d;
  logic [SEL_W-1:0]   idx;
  logic               busy;
  logic               wrap;

  modport master (
    output en, mode, i, load, dwell,
    input  d, idx, busy, wrap
  );

  modport slave (
    input  en, mode, i, load, dwell,
    output d, idx, busy, wrap
  );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with DIRECT, timed SCAN and ONESHOT modes.
// Every output is a flop, so d is glitch-free and at most one-hot.
module decoder_scan_n #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  decoder_scan_n_if.slave   bus
);
  localparam int OUT_W = 2 ** SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN,
    ST_PULSE
  } state_e;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_SCAN    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   d_q, d_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] timer_q, timer_d;
  logic [DWELL_W-1:0] dwell_r_q, dwell_r_d;

  mode_e              mode_c;
  logic [SEL_W-1:0]   idx_inc;
  logic               start_c;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  assign mode_c  = mode_e'(bus.mode);
  assign idx_inc = idx_q + SEL_W'(1);

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    wrap_d    = 1'b0;
    timer_d   = timer_q;
    dwell_r_d = dwell_r_q;
    start_c   = 1'b0;

    if (!bus.en) begin
      state_d = ST_IDLE;
      d_d     = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          d_d    = '0;
          busy_d = 1'b0;
          if (mode_c == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            d_d     = onehot(bus.i);
            idx_d   = bus.i;
          end else if (mode_c == MODE_SCAN && bus.load) begin
            state_d = ST_SCAN;
            start_c = 1'b1;
          end else if (mode_c == MODE_ONESHOT && bus.load) begin
            state_d = ST_PULSE;
            start_c = 1'b1;
          end
        end

        ST_DIRECT: begin
          if (mode_c != MODE_DIRECT) begin
            state_d = ST_IDLE;
            d_d     = '0;
          end else begin
            d_d   = onehot(bus.i);
            idx_d = bus.i;
          end
        end

        ST_SCAN: begin
          if (mode_c != MODE_SCAN) begin
            state_d = ST_IDLE;
            d_d     = '0;
            busy_d  = 1'b0;
          end else if (bus.load) begin
            start_c = 1'b1;
          end else if (timer_q != '0) begin
            timer_d = timer_q - DWELL_W'(1);
          end else begin
            // idx_inc wraps naturally at SEL_W bits, so all-ones is the last line
            idx_d   = idx_inc;
            d_d     = onehot(idx_inc);
            timer_d = dwell_r_q;
            wrap_d  = (idx_q == '1);
          end
        end

        ST_PULSE: begin
          if (mode_c != MODE_ONESHOT) begin
            state_d = ST_IDLE;
            d_d     = '0;
            busy_d  = 1'b0;
          end else if (bus.load) begin
            start_c = 1'b1;
          end else if (timer_q != '0) begin
            timer_d = timer_q - DWELL_W'(1);
          end else begin
            state_d = ST_IDLE;
            d_d     = '0;
            busy_d  = 1'b0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          d_d     = '0;
          busy_d  = 1'b0;
        end
      endcase

      // Shared launch path for a fresh or restarted SCAN/PULSE; the old dwell is discarded
      if (start_c) begin
        idx_d     = bus.i;
        d_d       = onehot(bus.i);
        dwell_r_d = bus.dwell;
        timer_d   = bus.dwell;
        busy_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      d_q       <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
      timer_q   <= '0;
      dwell_r_q <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      wrap_q    <= wrap_d;
      timer_q   <= timer_d;
      dwell_r_q <= dwell_r_d;
    end
  end

  assign bus.d    = d_q;
  assign bus.idx  = idx_q;
  assign bus.busy = busy_q;
  assign bus.wrap = wrap_q;
endmodule
